// File: rtl/alu_arb.sv
// alu_arb: arbitrates two requesters onto one shared combinational ALU (accept -> execute -> respond).
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration; default is fixed priority to requester 0.
`timescale 1ns/1ps
`default_nettype none

module alu_arb #(
    parameter int WIDTH = 4,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_res,
    output logic             busy,
    output logic             gnt_id,
    output logic [7:0]       done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] result;
    logic             win;
    logic             accept0;
    logic             accept1;
    logic             rsp_hs;

`ifdef ALU_ARB_RR_EN
    logic last;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        win = ~req0_valid;
        if (req0_valid && req1_valid) begin
            win = ~last;
        end
    end
`else
    assign win = ~req0_valid;
`endif

    // Readies are gated by reset so nothing is accepted while reset is asserted.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !win;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  win;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    // Only the granted side can have rsp valid, so the other side's ready is ignored.
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign rsp0_data  = result;
    assign rsp1_data  = result;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            result     <= '0;
            gnt_id     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            done_cnt   <= 8'd0;
`ifdef ALU_ARB_RR_EN
            last       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        alu_a  <= accept1 ? req1_a  : req0_a;
                        alu_b  <= accept1 ? req1_b  : req0_b;
                        alu_op <= accept1 ? req1_op : req0_op;
                        gnt_id <= accept1;
`ifdef ALU_ARB_RR_EN
                        last   <= accept1;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result     <= alu_res;
                    rsp0_valid <= !gnt_id;
                    rsp1_valid <=  gnt_id;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        done_cnt   <= done_cnt + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arb.sv
// tb_alu_arb: scoreboard bench for alu_arb with a transaction-level model and a stub ALU.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [3:0] rsp0_data, rsp1_data;
    logic [3:0] alu_a, alu_b, alu_res;
    logic [2:0] alu_op;
    logic       busy, gnt_id;
    logic [7:0] done_cnt;

    always #5 clk = ~clk;

    alu_arb #(.WIDTH(4), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .busy(busy), .gnt_id(gnt_id), .done_cnt(done_cnt)
    );

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {3'b000, (a < b)};
            default: return {3'b000, (a == b)};
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_a, alu_b, alu_op);

    typedef struct packed {
        logic       id;
        logic [3:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    // Transaction-level model: phase 0 idle, 1 executing, 2 responding.
    bit         m_known = 1'b0;
    int         m_phase = 0;
    bit         m_gnt = 1'b0;
    bit         m_last = 1'b1;
    logic [3:0] m_a = '0, m_b = '0;
    logic [2:0] m_op = '0;
    int         m_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit v0, input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                         input bit v1, input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                         input bit r0, input bit r1, input bit rn);
        bit win;
        bit exp_r0, exp_r1;
        @(negedge clk);
        rst_n = rn;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
`ifdef ALU_ARB_RR_EN
        win = (v0 && v1) ? !m_last : !v0;
`else
        win = !v0;
`endif
        exp_r0 = rn && (m_phase == 0) && v0 && !win;
        exp_r1 = rn && (m_phase == 0) && v1 &&  win;
        if (m_known) begin
            check("busy",       32'(busy),       32'(m_phase != 0));
            check("gnt_id",     32'(gnt_id),     32'(m_gnt));
            check("alu_a",      32'(alu_a),      32'(m_a));
            check("alu_b",      32'(alu_b),      32'(m_b));
            check("alu_op",     32'(alu_op),     32'(m_op));
            check("done_cnt",   32'(done_cnt),   32'(m_done % 256));
            check("req0_ready", 32'(req0_ready), 32'(exp_r0));
            check("req1_ready", 32'(req1_ready), 32'(exp_r1));
            check("rsp0_valid", 32'(rsp0_valid), 32'((m_phase == 2) && !m_gnt));
            check("rsp1_valid", 32'(rsp1_valid), 32'((m_phase == 2) &&  m_gnt));
        end
        if (!rn) begin
            m_known = 1'b1; m_phase = 0; m_gnt = 1'b0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_op = '0; m_done = 0;
            exp_q.delete();
        end else if (m_known) begin
            if (m_phase == 0) begin
                if (v0 || v1) begin
                    m_gnt  = win;
                    m_last = win;
                    m_a    = win ? a1  : a0;
                    m_b    = win ? b1  : b0;
                    m_op   = win ? op1 : op0;
                    exp_q.push_back('{id: win, data: alu_fn(m_a, m_b, m_op)});
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_gnt ? r1 : r0) begin
                m_phase = 0;
                m_done++;
            end
        end
    endtask

    task automatic idle(input int n, input bit r0, input bit r1);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 1);
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && (rsp0_valid === 1'b1 || rsp1_valid === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp0_valid=%0b rsp1_valid=%0b required no response", rsp0_valid, rsp1_valid);
                end else begin
                    check("rsp_id",   32'(rsp1_valid), 32'(exp_q[0].id));
                    check("rsp_data", 32'(rsp1_valid ? rsp1_data : rsp0_data), 32'(exp_q[0].data));
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0; rsp0_ready = 0; rsp1_ready = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single add, then sub with wrap on requester 1.
        cycle(1, 4'd3, 4'd5, 3'd0, 0, 0, 0, 0, 1, 1, 1);
        idle(4, 1, 1);
        cycle(0, 0, 0, 0, 1, 4'd2, 4'd5, 3'd1, 1, 1, 1);
        idle(4, 1, 1);
        // Continuous contention with both ready.
        for (int i = 0; i < 12; i++) cycle(1, 4'(i), 4'd1, 3'd0, 1, 4'(i), 4'd2, 3'd4, 1, 1, 1);
        idle(2, 1, 1);
        // Backpressure on requester 0 while both keep requesting.
        cycle(1, 4'd7, 4'd1, 3'd0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) cycle(1, 4'd9, 4'd9, 3'd7, 1, 4'd4, 4'd4, 3'd2, 0, 1, 1);
        idle(3, 1, 1);
        // Reset while executing discards the operation.
        cycle(1, 4'd6, 4'd6, 3'd7, 0, 0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(4, 1, 1);
        // Long random run (no resets) to wrap done_cnt, then random with sporadic resets.
        for (int i = 0; i < 2600; i++)
            cycle($urandom_range(3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(3) != 0, $urandom_range(3) != 0, 1);
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(1) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(1) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(2) != 0, $urandom_range(2) != 0, $urandom_range(40) != 0);
        idle(6, 1, 1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand and result width, matched to the shared ALU.
REQ-002 The block SHALL have parameter OP_W, default 3, meaning the ALU opcode width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 The block SHALL have ports req0_valid/req1_valid, input, 1, meaning requester N presents an operation.
REQ-006 The block SHALL have ports req0_ready/req1_ready, output, 1, meaning the block accepts requester N's operation this cycle.
REQ-007 The block SHALL have ports req0_a/req1_a and req0_b/req1_b, input, WIDTH, meaning the operands.
REQ-008 The block SHALL have ports req0_op/req1_op, input, OP_W, meaning the ALU opcode (000 add … 111 equal).
REQ-009 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1, meaning a result is available for requester N.
REQ-010 The block SHALL have ports rsp0_ready/rsp1_ready, input, 1, meaning requester N consumes its result.
REQ-011 The block SHALL have ports rsp0_data/rsp1_data, output, WIDTH, meaning the result for requester N.
REQ-012 The block SHALL have ports alu_a, alu_b, alu_op, output, WIDTH/WIDTH/OP_W, meaning registered drive to the shared combinational ALU.
REQ-013 The block SHALL have port alu_res, input, WIDTH, meaning the raw ALU result.
REQ-014 The block SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-015 The block SHALL have port gnt_id, output, 1, meaning the requester currently owning the ALU.
REQ-016 The block SHALL have port done_cnt, output, 8, meaning completed responses, modulo 256.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-018 In IDLE, reqN_ready SHALL be asserted combinationally only for the arbitration winner N; both readies SHALL be low in EXEC and RESP.
REQ-019 On reqN_valid&reqN_ready, the block SHALL register a/b/op onto alu_a/alu_b/alu_op, set gnt_id=N and go to EXEC.
REQ-020 In EXEC (exactly one cycle), the block SHALL capture alu_res into the result register and go to RESP.
REQ-021 In RESP, rspN_valid SHALL be high only for N=gnt_id, with rspN_data equal to the captured result, held stable until rspN_ready.
REQ-022 On rspN_valid&rspN_ready, the block SHALL return to IDLE and increment done_cnt, which wraps 255→0.
REQ-023 A request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-024 Timing: accept at cycle T, rsp_valid at T+2, next accept no earlier than the cycle after the response handshake (minimum 3 cycles per operation).
REQ-025 The rsp_ready of the non-granted requester SHALL be ignored.
REQ-026 alu_a/alu_b/alu_op SHALL hold their values outside the accept cycle.
REQ-027 The block SHALL pass results through unmodified; opcode semantics are owned by the ALU.
REQ-028 A requester whose valid drops before grant SHALL NOT be served.

Reset
REQ-029 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, all ready/valid outputs 0, alu_a/alu_b/alu_op=0, result register=0, gnt_id=0, done_cnt=0, and round-robin pointer last=1.
REQ-030 A reset during EXEC or RESP SHALL discard the in-flight operation without a response and without incrementing done_cnt.

Configuration
REQ-031 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: if both requesters are valid, the requester not equal to last wins; last updates to the winner on accept.
REQ-032 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins when valid, and no pointer register exists.

Verification
REQ-033 Single add: req0 a=3 b=5 op=000 → alu_a=3, alu_b=5 next cycle; rsp0_valid at T+2 with rsp0_data=8; done_cnt=1.
REQ-034 Sub wrap: req1 a=2 b=5 op=001 → rsp1_data=4'hD; rsp0_valid stays 0 throughout.
REQ-035 Contention with ALU_ARB_RR_EN: both valid continuously, rsp_ready=1 → grants after reset are 0,1,0,1; without the macro, the grants are 0,0,0,0.
REQ-036 Backpressure: rsp0_ready held 0 for 5 cycles → rsp0_valid and rsp0_data stable, req ready stays low, busy=1; the block completes when ready rises.
REQ-037 Reset mid-op: rst_n=0 during EXEC → next cycle all outputs are at reset values, done_cnt=0, and no response is issued.
REQ-038 Counter wrap: 256 completed operations → done_cnt=0.
